// File: rtl/adc_scan_seq.sv
// adc_scan_seq: multi-channel SAR ADC scan sequencer with 2-entry result FIFO.
// Drives the mux select and SOC pulse, captures on EOC and tags results by channel.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   en                global enable; low freezes all state
//   start, stop       scan request (IDLE only) / abort (any non-IDLE state)
//   mode_cont         1 = rescan after interval, 0 = single scan
//   ch_mask           enabled channels, latched at scan start
//   settle            mux settle time (SETTLE lasts settle+1 cycles)
//   interval          gap between scans in continuous mode
//   sar_soc           start-of-conversion to SAR controller
//   sar_eoc, sar_data end-of-conversion and result from SAR controller
//   ch_sel            analog mux select
//   res_*             FIFO head (data, channel, valid) and consumer ready
//   busy, scan_done   activity flag and end-of-scan pulse
//   ovf, ovf_clr      sticky drop flag and its clear
module adc_scan_seq #(
  parameter int SIZE = 12,
  parameter int NCH  = 8,
  parameter int CHW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  input  logic            stop,
  input  logic            mode_cont,
  input  logic [NCH-1:0]  ch_mask,
  input  logic [3:0]      settle,
  input  logic [15:0]     interval,
  output logic            sar_soc,
  input  logic            sar_eoc,
  input  logic [SIZE-1:0] sar_data,
  output logic [CHW-1:0]  ch_sel,
  output logic [SIZE-1:0] res_data,
  output logic [CHW-1:0]  res_ch,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy,
  output logic            scan_done,
  output logic            ovf,
  input  logic            ovf_clr
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, SOC, WAIT, NEXT, GAP
  } state_t;

  state_t         state, state_n;
  logic [CHW-1:0] ch_n;
  logic [NCH-1:0] mask_q, mask_n;
  logic [15:0]    cnt, cnt_n;
  logic           push;

  // {found, index} of the lowest set bit of m at or above lo
  function automatic logic [CHW:0] first_set(
    input logic [NCH-1:0] m,
    input int             lo
  );
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, i[CHW-1:0]};
    end
    return r;
  endfunction

  logic [CHW:0] nxt, fst;

  assign nxt = first_set(mask_q, int'(ch_sel) + 1);
  assign fst = first_set(ch_mask, 0);

  always_comb begin
    state_n = state;
    ch_n    = ch_sel;
    mask_n  = mask_q;
    cnt_n   = cnt;
    push    = 1'b0;
    if (en) begin
      if (stop && state != IDLE) begin
        state_n = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && |ch_mask) begin
              mask_n  = ch_mask;
              ch_n    = fst[CHW-1:0];
              cnt_n   = {12'b0, settle};
              state_n = SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == 16'd0) state_n = SOC;
            else cnt_n = cnt - 16'd1;
          end
          SOC: state_n = WAIT;
          WAIT: begin
            if (sar_eoc) begin
              push    = 1'b1;
              state_n = NEXT;
            end
          end
          NEXT: begin
            if (nxt[CHW]) begin
              ch_n    = nxt[CHW-1:0];
              cnt_n   = {12'b0, settle};
              state_n = SETTLE;
            end else if (!mode_cont) begin
              state_n = IDLE;
            end else if (interval != 16'd0) begin
              cnt_n   = interval;
              state_n = GAP;
            end else if (|ch_mask) begin
              // zero interval: rescan at once from a fresh mask
              mask_n  = ch_mask;
              ch_n    = fst[CHW-1:0];
              cnt_n   = {12'b0, settle};
              state_n = SETTLE;
            end else begin
              mask_n  = ch_mask;
              state_n = IDLE;
            end
          end
          GAP: begin
            if (cnt != 16'd0) begin
              cnt_n = cnt - 16'd1;
            end else begin
              mask_n = ch_mask;
              if (|ch_mask) begin
                ch_n    = fst[CHW-1:0];
                cnt_n   = {12'b0, settle};
                state_n = SETTLE;
              end else begin
                state_n = IDLE;
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch_sel <= '0;
      mask_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      ch_sel <= ch_n;
      mask_q <= mask_n;
      cnt    <= cnt_n;
    end
  end

  assign sar_soc   = (state == SOC);
  assign busy      = (state != IDLE);
  assign scan_done = (state == NEXT) && !nxt[CHW] && !stop;

  // 2-entry first-word fall-through result FIFO
  logic [SIZE-1:0] dmem [2];
  logic [CHW-1:0]  cmem [2];
  logic            wptr, rptr;
  logic [1:0]      fcnt;
  logic            pop, push_ok, drop;

  assign res_valid = (fcnt != 2'd0);
  assign pop       = en && res_valid && res_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok   = push && (fcnt != 2'd2 || pop);
  assign drop      = push && !push_ok;
  assign res_data  = dmem[rptr];
  assign res_ch    = cmem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        dmem[i] <= '0;
        cmem[i] <= '0;
      end
      wptr <= 1'b0;
      rptr <= 1'b0;
      fcnt <= 2'd0;
      ovf  <= 1'b0;
    end else if (en) begin
      if (push_ok) begin
        dmem[wptr] <= sar_data;
        cmem[wptr] <= ch_sel;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fcnt <= fcnt + {1'b0, push_ok} - {1'b0, pop};
      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: directed bench for adc_scan_seq.
// SAR stand-in, queue-based result model and per-cycle output compare.
module tb_adc_scan_seq;
  localparam int SIZE = 12;
  localparam int NCH  = 8;
  localparam int CHW  = 3;
  localparam int D    = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            mode_cont = 1'b0;
  logic [NCH-1:0]  ch_mask = '0;
  logic [3:0]      settle = 4'd2;
  logic [15:0]     interval = 16'd10;
  logic            sar_soc;
  logic            sar_eoc = 1'b0;
  logic [SIZE-1:0] sar_data = '0;
  logic [CHW-1:0]  ch_sel;
  logic [SIZE-1:0] res_data;
  logic [CHW-1:0]  res_ch;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            busy;
  logic            scan_done;
  logic            ovf;
  logic            ovf_clr = 1'b0;

  adc_scan_seq #(.SIZE(SIZE), .NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
    .mode_cont(mode_cont), .ch_mask(ch_mask), .settle(settle),
    .interval(interval), .sar_soc(sar_soc), .sar_eoc(sar_eoc),
    .sar_data(sar_data), .ch_sel(ch_sel), .res_data(res_data),
    .res_ch(res_ch), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .scan_done(scan_done), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { int ch; int d; } ent_t;

  ent_t mq[$];
  int   popped[$];
  int   plan[$];
  int   soc_t[$];
  int   soc_n = 0;
  int   done_n = 0;
  int   conv = 0;
  int   cur_ch = 0;
  logic movf = 1'b0;
  logic [SIZE-1:0] dseq = 12'h0a5;

  // SAR stand-in plus expected FIFO/ovf behaviour
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      conv = 0;
      movf = 1'b0;
      sar_eoc <= 1'b0;
    end else if (en) begin
      bit setovf;
      setovf = 1'b0;
      if (mq.size() > 0 && res_ready) begin
        popped.push_back(mq[0].ch);
        void'(mq.pop_front());
      end
      if (sar_eoc && !stop) begin
        ent_t e;
        e.ch = cur_ch;
        e.d  = int'(sar_data);
        if (mq.size() < 2) mq.push_back(e);
        else setovf = 1'b1;
      end
      if (setovf) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
      if (scan_done) done_n++;
      if (stop) begin
        conv = 0;
        sar_eoc <= 1'b0;
      end else begin
        if (sar_soc) begin
          soc_n++;
          soc_t.push_back(cyc);
          if (plan.size() == 0) begin
            chk("unexpected_soc", 1, 0);
          end else begin
            cur_ch = plan.pop_front();
            chk("soc_ch_sel", ch_sel, cur_ch);
          end
          conv = D;
        end else if (conv > 0) begin
          conv--;
        end
        sar_eoc <= (conv == 1);
        if (conv == 1) begin
          sar_data <= dseq;
          dseq = dseq + 12'h135;
        end
      end
    end
  end

  // every-cycle compare of FIFO head and ovf against the model
  always @(negedge clk) begin
    chk("res_valid", res_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("res_data", res_data, mq[0].d);
      chk("res_ch", res_ch, mq[0].ch);
    end
    chk("ovf", ovf, movf);
  end

  int t0;

  task automatic do_start(input logic [NCH-1:0] m);
    ch_mask = m;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_socs(input int n, input int budget);
    int k;
    k = 0;
    while (soc_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("soc_timeout", soc_n >= n, 1);
  endtask

  task automatic wait_eoc(input int budget);
    int k;
    k = 0;
    while (sar_eoc !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("eoc_timeout", sar_eoc, 1);
  endtask

  initial begin
    int s0, d0, k, s, hi;
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, k, s, hi;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_soc", sar_soc, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_done", scan_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single scan over 0,5,7
    plan = '{0, 5, 7};
    soc_t.delete();
    popped.delete();
    d0 = done_n;
    do_start(8'hA1);
    k = 0;
    while (scan_done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("s1_scan_done", scan_done, 1);
    chk("s1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("s1_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    chk("s1_first_soc", soc_t[0] - t0, 4);
    chk("s1_soc_gap1", soc_t[1] - soc_t[0], 19);
    chk("s1_soc_gap2", soc_t[2] - soc_t[1], 19);
    chk("s1_done_cnt", done_n - d0, 1);
    chk("s1_n_results", popped.size(), 3);
    chk("s1_res0", popped[0], 0);
    chk("s1_res1", popped[1], 5);
    chk("s1_res2", popped[2], 7);

    // continuous, mask change mid-scan applies to next scan
    plan = '{0, 1, 2};
    soc_t.delete();
    popped.delete();
    d0 = done_n;
    s0 = soc_n;
    mode_cont = 1'b1;
    do_start(8'h03);
    ch_mask = 8'h04;
    wait_socs(s0 + 3, 400);
    mode_cont = 1'b0;
    wait_idle(300);
    repeat (3) @(negedge clk);
    chk("c_soc_gap_in", soc_t[1] - soc_t[0], 19);
    chk("c_soc_gap_scan", soc_t[2] - soc_t[1], 30);
    chk("c_plan_used", plan.size(), 0);
    chk("c_done_cnt", done_n - d0, 2);
    chk("c_res2", popped[2], 2);
    chk("c_stay_idle", busy, 0);

    // overflow with stalled consumer
    res_ready = 1'b0;
    plan = '{0, 1, 2};
    do_start(8'h07);
    wait_idle(300);
    chk("o_ovf_set", ovf, 1);
    chk("o_head_ch", res_ch, 0);
    chk("o_valid", res_valid, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("o_ovf_clr", ovf, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("o_second_ch", res_ch, 1);
    @(negedge clk);
    chk("o_drained", res_valid, 0);

    // push and pop together on a full FIFO
    res_ready = 1'b0;
    plan = '{0, 1, 2};
    s0 = soc_n;
    do_start(8'h07);
    wait_socs(s0 + 3, 400);
    wait_eoc(100);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("f_no_ovf", ovf, 0);
    chk("f_head_ch", res_ch, 1);
    chk("f_valid", res_valid, 1);
    wait_idle(100);
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("f_drained", res_valid, 0);

    // stop coincident with eoc, then a start with empty mask
    plan = '{0};
    d0 = done_n;
    do_start(8'h01);
    wait_eoc(100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("st_idle", busy, 0);
    chk("st_no_push", res_valid, 0);
    chk("st_no_done", done_n - d0, 0);
    s0 = soc_n;
    do_start(8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("z_busy", busy, 0);
      @(negedge clk);
    end
    chk("z_no_soc", soc_n - s0, 0);

    // en low during SETTLE and during SOC
    plan = '{0};
    s0 = soc_n;
    do_start(8'h01);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    k = 0;
    while (sar_soc !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    s = cyc;
    chk("e_soc_time", s - t0, 9);
    en = 1'b0;
    hi = 1;
    repeat (5) begin
      @(negedge clk);
      hi += int'(sar_soc);
    end
    en = 1'b1;
    chk("e_soc_len", hi, 6);
    @(negedge clk);
    chk("e_soc_low", sar_soc, 0);
    chk("e_soc_once", soc_n - s0, 1);
    chk("e_soc_edge", soc_t[soc_t.size() - 1], s + 5);
    wait_idle(100);
    repeat (2) @(negedge clk);

    // asynchronous reset mid-scan
    res_ready = 1'b0;
    plan = '{0, 1};
    do_start(8'h03);
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("r_pre_ch", ch_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_soc", sar_soc, 0);
    chk("r_valid", res_valid, 0);
    chk("r_data", res_data, 0);
    chk("r_ch", res_ch, 0);
    chk("r_ch_sel", ch_sel, 0);
    chk("r_ovf", ovf, 0);
    chk("r_done", scan_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    plan.delete();
    res_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
